// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver: synchronizes and filters the pins, deframes
// 11-bit device frames and folds E0/F0 prefixes into flags on the decoded code.
module ps2_scancode_rx #(
  parameter int clk_mhz    = 25,
  parameter int timeout_us = 200,
  parameter int filter_len = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW       = $clog2(filter_len + 1);
  localparam int TO_LIMIT = clk_mhz * timeout_us;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]            clk_sync_reg;
  logic [1:0]            data_sync_reg;
  logic [filter_len-1:0] data_dly_reg;
  logic [CW-1:0]         filt_cnt_reg;
  logic                  filt_reg;
  logic                  filt_prev_reg;
  logic                  fall;
  logic                  data_s;

  logic [1:0]  state_reg, state_next;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;
  logic        par_acc_reg;
  logic        par_ok_reg;
  logic        ext_reg;
  logic        brk_reg;
  logic [TW-1:0] to_cnt_reg;
  logic        timed_out;

  logic [7:0]  code_reg;
  logic        code_valid_reg;
  logic        is_break_reg;
  logic        is_extended_reg;
  logic        frame_err_reg;
  logic        busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2clk};
      data_sync_reg <= {data_sync_reg[0], ps2data};
    end
  end

  // Data is delayed by as many cycles as the clock filter needs to switch,
  // so the sampled bit corresponds to the device's falling edge.
  generate
    for (genvar gi = 0; gi < filter_len; gi++) begin : g_data_dly
      always_ff @(posedge clk) begin
        if (reset) begin
          data_dly_reg[gi] <= 1'b1;
        end else if (gi == 0) begin
          data_dly_reg[gi] <= data_sync_reg[1];
        end else begin
          data_dly_reg[gi] <= data_dly_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign data_s = data_dly_reg[filter_len-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_reg      <= 1'b1;
      filt_prev_reg <= 1'b1;
      filt_cnt_reg  <= '0;
    end else begin
      filt_prev_reg <= filt_reg;
      if (clk_sync_reg[1] == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == CW'(filter_len - 1)) begin
        filt_reg     <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  assign fall      = filt_prev_reg & ~filt_reg;
  assign timed_out = (state_reg != IDLE) && (to_cnt_reg == TW'(TO_LIMIT));

  always_comb begin
    state_next = state_reg;
    if (fall) begin
      case (state_reg)
        IDLE:    if (!data_s) state_next = DATA;
        DATA:    if (idx_reg == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else if (timed_out) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= 3'd0;
      shift_reg       <= 8'h00;
      par_acc_reg     <= 1'b0;
      par_ok_reg      <= 1'b0;
      ext_reg         <= 1'b0;
      brk_reg         <= 1'b0;
      to_cnt_reg      <= '0;
      code_reg        <= 8'h00;
      code_valid_reg  <= 1'b0;
      is_break_reg    <= 1'b0;
      is_extended_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= (state_next != IDLE);
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      if (state_reg == IDLE || fall) begin
        to_cnt_reg <= '0;
      end else if (!timed_out) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end

      if (fall) begin
        case (state_reg)
          IDLE: begin
            idx_reg     <= 3'd0;
            par_acc_reg <= 1'b0;
          end
          DATA: begin
            shift_reg   <= {data_s, shift_reg[7:1]};
            par_acc_reg <= par_acc_reg ^ data_s;
            if (idx_reg != 3'd7) idx_reg <= idx_reg + 1'b1;
          end
          PARITY: par_ok_reg <= par_acc_reg ^ data_s;
          STOP: begin
            if (data_s && par_ok_reg) begin
              if (shift_reg == 8'hE0) begin
                ext_reg <= 1'b1;
              end else if (shift_reg == 8'hF0) begin
                brk_reg <= 1'b1;
              end else begin
                code_reg        <= shift_reg;
                code_valid_reg  <= 1'b1;
                is_break_reg    <= brk_reg;
                is_extended_reg <= ext_reg;
                ext_reg         <= 1'b0;
                brk_reg         <= 1'b0;
              end
            end else begin
              frame_err_reg <= 1'b1;
              ext_reg       <= 1'b0;
              brk_reg       <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign code        = code_reg;
  assign code_valid  = code_valid_reg;
  assign is_break    = is_break_reg;
  assign is_extended = is_extended_reg;
  assign frame_err   = frame_err_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: a table of whole-frame vectors plus
// hand-written timeout, glitch and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  logic       clk;
  logic       reset;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;

  ps2_scancode_rx #(.clk_mhz(25), .timeout_us(200), .filter_len(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .code        (code),
    .code_valid  (code_valid),
    .is_break    (is_break),
    .is_extended (is_extended),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;  // 25 MHz

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    bit         bad_par;
    int         half;
    int         exp_valid;
    logic [7:0] exp_code;
    bit         exp_brk;
    bit         exp_ext;
    int         exp_err;
  } vec_t;

  vec_t vecs[7];

  int n_vec = 0;
  int n_bad = 0;
  int valid_total = 0;
  int err_total = 0;
  logic [7:0] cap_code = 8'h00;
  logic       cap_brk = 1'b0;
  logic       cap_ext = 1'b0;

  always @(negedge clk) begin
    if (code_valid) begin
      valid_total <= valid_total + 1;
      cap_code    <= code;
      cap_brk     <= is_break;
      cap_ext     <= is_extended;
    end
    if (frame_err) err_total <= err_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends the first nbits bits of a frame; busy is sampled mid-low on bits 0..9.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input int half, output int low_busy);
    logic [10:0] bits;
    bits     = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    low_busy = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2data = bits[i];
      repeat (half) @(posedge clk);
      ps2clk = 1'b0;
      repeat (half / 2) @(negedge clk);
      if (i < 10 && busy !== 1'b1) low_busy++;
      repeat (half - half / 2) @(posedge clk);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
    if (nbits == 11) repeat (half) @(posedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lb, v0, e0;
    logic [7:0] bytes[3];

    vecs[0] = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 1000, 1, 8'h1C, 1'b0, 1'b0, 0};
    vecs[1] = '{8'hF0, 8'h1C, 8'h00, 2, 1'b0, 100,  1, 8'h1C, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 100,  1, 8'h1C, 1'b0, 1'b0, 0};
    vecs[3] = '{8'hE0, 8'hF0, 8'h75, 3, 1'b0, 100,  1, 8'h75, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h32, 8'h00, 8'h00, 1, 1'b0, 100,  1, 8'h32, 1'b0, 1'b0, 0};
    vecs[5] = '{8'h1C, 8'h00, 8'h00, 1, 1'b1, 100,  0, 8'h32, 1'b0, 1'b0, 1};
    vecs[6] = '{8'h32, 8'h00, 8'h00, 1, 1'b0, 100,  1, 8'h32, 1'b0, 1'b0, 0};

    ps2clk  = 1'b1;
    ps2data = 1'b1;
    do_reset();
    check("reset code", code, 8'h00);
    check("reset code_valid", code_valid, 0);
    check("reset is_break", is_break, 0);
    check("reset is_extended", is_extended, 0);
    check("reset frame_err", frame_err, 0);
    check("reset busy", busy, 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      v0 = valid_total;
      e0 = err_total;
      bytes[0] = vecs[v].b0;
      bytes[1] = vecs[v].b1;
      bytes[2] = vecs[v].b2;
      for (int k = 0; k < vecs[v].n; k++) begin
        send_frame(bytes[k], (k == vecs[v].n - 1) && vecs[v].bad_par, 11, vecs[v].half, lb);
        check($sformatf("vec%0d byte%0d busy in frame (low samples)", v, k), lb, 0);
      end
      @(negedge clk);
      check($sformatf("vec%0d valid pulses", v), valid_total - v0, vecs[v].exp_valid);
      check($sformatf("vec%0d err pulses", v), err_total - e0, vecs[v].exp_err);
      check($sformatf("vec%0d code", v), code, vecs[v].exp_code);
      check($sformatf("vec%0d busy after", v), busy, 0);
      if (vecs[v].exp_valid > 0) begin
        check($sformatf("vec%0d code at strobe", v), cap_code, vecs[v].exp_code);
        check($sformatf("vec%0d is_break", v), cap_brk, vecs[v].exp_brk);
        check($sformatf("vec%0d is_extended", v), cap_ext, vecs[v].exp_ext);
      end
    end

    // Partial frame then clock stalled high: abandon after 200 us.
    v0 = valid_total;
    e0 = err_total;
    send_frame(8'h15, 1'b0, 6, 100, lb);
    check("timeout partial busy", lb, 0);
    repeat (4800) @(negedge clk);  // ~4900 cycles after last fall
    check("timeout busy before limit", busy, 1);
    repeat (200) @(negedge clk);   // ~5100 cycles after last fall
    check("timeout busy after limit", busy, 0);
    repeat (1150) @(posedge clk);
    check("timeout no strobe", valid_total - v0, 0);
    check("timeout no err", err_total - e0, 0);
    send_frame(8'h21, 1'b0, 11, 100, lb);
    @(negedge clk);
    check("after timeout valid", valid_total - v0, 1);
    check("after timeout code", cap_code, 8'h21);
    check("after timeout brk", cap_brk, 0);

    // Short low glitch on the clock with data low must not start a frame.
    v0 = valid_total;
    e0 = err_total;
    ps2data = 1'b0;
    @(posedge clk);
    ps2clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2clk = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch busy", busy, 0);
    ps2data = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch busy late", busy, 0);
    check("glitch no strobe", valid_total - v0, 0);
    check("glitch no err", err_total - e0, 0);

    // Break prefix, then reset in the middle of the next frame.
    send_frame(8'hF0, 1'b0, 11, 100, lb);
    send_frame(8'h33, 1'b0, 6, 100, lb);
    do_reset();
    check("midreset code", code, 8'h00);
    check("midreset code_valid", code_valid, 0);
    check("midreset is_break", is_break, 0);
    check("midreset is_extended", is_extended, 0);
    check("midreset frame_err", frame_err, 0);
    check("midreset busy", busy, 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    v0 = valid_total;
    send_frame(8'h1C, 1'b0, 11, 100, lb);
    @(negedge clk);
    check("post-reset valid", valid_total - v0, 1);
    check("post-reset code", cap_code, 8'h1C);
    check("post-reset brk cleared", cap_brk, 0);
    check("post-reset ext", cap_ext, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
